// File: rtl/ex_stage_ctrl.sv
// Execute-stage handshake controller: consumes the ID->EX valids, serializes up to two
// MDU operations per bundle, kills line2 and redirects fetch on a line1 mispredict.
//
// state   | meaning
// IDLE    | bundle in EX has no MDU work pending (or no bundle)
// L1_BUSY | line1 MDU op in flight, cnt = cycles remaining
// L2_BUSY | line2 MDU op in flight, cnt = cycles remaining
// DONE    | all MDU work finished, waiting for EX->MEM to accept
module ex_stage_ctrl #(
   parameter int LAT_W = 6,
   parameter int PC_W  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             line1_now_valid_i,
   input  logic             line2_now_valid_i,
   input  logic [LAT_W-1:0] line1_lat_i,
   input  logic [LAT_W-1:0] line2_lat_i,
   input  logic             line1_br_mispredict_i,
   input  logic [PC_W-1:0]  line1_br_target_i,
   input  logic             excep_flush_i,
   input  logic             next_allowin_i,
   output logic             now_allowin_o,
   output logic             line1_to_next_valid_o,
   output logic             line2_to_next_valid_o,
   output logic             mdu_start_o,
   output logic             mdu_sel_line_o,
   output logic             redirect_valid_o,
   output logic [PC_W-1:0]  redirect_pc_o,
   output logic             ex_busy_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      L1_BUSY = 2'd1,
      L2_BUSY = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [LAT_W-1:0] cnt, cnt_nxt;
   logic             redirect_sent, redirect_sent_nxt;

   logic any_v, l1m, l2m, kill2;
   logic ready_go, handoff, cnt_one;
   logic mdu_start, mdu_sel, redirect_valid;

   assign any_v   = line1_now_valid_i | line2_now_valid_i;
   assign l1m     = line1_now_valid_i & (line1_lat_i != '0);
   assign kill2   = line1_now_valid_i & line1_br_mispredict_i;
   assign l2m     = line2_now_valid_i & (line2_lat_i != '0) & ~kill2;
   assign cnt_one = (cnt == LAT_W'(1));

   assign ready_go       = ((state == IDLE) & ~l1m & ~l2m) | (state == DONE);
   assign handoff        = ready_go & next_allowin_i & any_v;
   assign redirect_valid = kill2 & ~redirect_sent & ~excep_flush_i;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      mdu_start = 1'b0;
      mdu_sel   = 1'b0;
      case (state)
         IDLE: begin
            if (l1m) begin
               state_nxt = L1_BUSY;
               cnt_nxt   = line1_lat_i;
               mdu_start = 1'b1;
            end else if (l2m) begin
               state_nxt = L2_BUSY;
               cnt_nxt   = line2_lat_i;
               mdu_start = 1'b1;
               mdu_sel   = 1'b1;
            end
         end
         L1_BUSY: begin
            cnt_nxt = cnt - LAT_W'(1);
            if (cnt_one) begin
               // line2 op launches on line1's last busy cycle, never earlier
               if (l2m) begin
                  state_nxt = L2_BUSY;
                  cnt_nxt   = line2_lat_i;
                  mdu_start = 1'b1;
                  mdu_sel   = 1'b1;
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         L2_BUSY: begin
            cnt_nxt = cnt - LAT_W'(1);
            if (cnt_one) state_nxt = DONE;
         end
         DONE: begin
            if (next_allowin_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      if (excep_flush_i) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end
   end

   always_comb begin
      redirect_sent_nxt = redirect_sent;
      if (excep_flush_i || handoff) redirect_sent_nxt = 1'b0;
      else if (redirect_valid)      redirect_sent_nxt = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         redirect_sent <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         redirect_sent <= redirect_sent_nxt;
      end
   end

   assign now_allowin_o         = ~any_v | (ready_go & next_allowin_i);
   assign line1_to_next_valid_o = line1_now_valid_i & ready_go & ~excep_flush_i;
   assign line2_to_next_valid_o = line2_now_valid_i & ready_go & ~excep_flush_i & ~kill2;
   assign mdu_start_o           = mdu_start & ~excep_flush_i;
   assign mdu_sel_line_o        = mdu_sel;
   assign redirect_valid_o      = redirect_valid;
   assign redirect_pc_o         = redirect_valid ? line1_br_target_i : '0;
   assign ex_busy_o             = (state == L1_BUSY) | (state == L2_BUSY);

endmodule

// File: tb/tb_ex_stage_ctrl.sv
// Bench for ex_stage_ctrl: IDLE-cycle vector table, directed multi-cycle sequences,
// and random bundles checked against a bundle-age reference model.
module tb_ex_stage_ctrl;
   localparam int LAT_W = 6;
   localparam int PC_W  = 32;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             v1, v2, mis, flush, nal;
   logic [LAT_W-1:0] lat1, lat2;
   logic [PC_W-1:0]  tgt;
   logic             allow, t1, t2, start, sel, redir, busy;
   logic [PC_W-1:0]  pc;

   always #5 clk = ~clk;

   ex_stage_ctrl #(.LAT_W(LAT_W), .PC_W(PC_W)) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .line1_now_valid_i     (v1),
      .line2_now_valid_i     (v2),
      .line1_lat_i           (lat1),
      .line2_lat_i           (lat2),
      .line1_br_mispredict_i (mis),
      .line1_br_target_i     (tgt),
      .excep_flush_i         (flush),
      .next_allowin_i        (nal),
      .now_allowin_o         (allow),
      .line1_to_next_valid_o (t1),
      .line2_to_next_valid_o (t2),
      .mdu_start_o           (start),
      .mdu_sel_line_o        (sel),
      .redirect_valid_o      (redir),
      .redirect_pc_o         (pc),
      .ex_busy_o             (busy)
   );

   int n_chk = 0;
   int n_pass = 0;

   // reference model: age of the current bundle in EX, and whether it already redirected
   int m_age = 0;
   bit m_rd = 1'b0;
   bit new_b = 1'b1;

   int st_cyc, st_start, st_last_start, st_busy, st_redir, st_t1, st_t2, st_first_allow;

   typedef struct {
      logic             v1, v2, mis, flush, nal;
      logic [LAT_W-1:0] lat1, lat2;
      logic [5:0]       exp;   // allow, t1, t2, start, sel, redir
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic vec_t mk(input logic [4:0] ctl, input int l1, input int l2, input logic [5:0] exp);
      vec_t r;
      {r.v1, r.v2, r.mis, r.flush, r.nal} = ctl;
      r.lat1 = LAT_W'(l1);
      r.lat2 = LAT_W'(l2);
      r.exp  = exp;
      return r;
   endfunction

   function automatic logic [LAT_W-1:0] rnd_lat();
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) return '0;
      if (r < 8) return LAT_W'(r - 3);
      if (r == 8) return LAT_W'(1);
      return LAT_W'(63);
   endfunction

   task automatic clr_stats();
      st_cyc = 0; st_start = 0; st_last_start = -1; st_busy = 0;
      st_redir = 0; st_t1 = 0; st_t2 = 0; st_first_allow = -1;
   endtask

   // Check one cycle against the model, then advance one clock edge.
   task automatic tick();
      bit l1m, l2m, kill2, ready, e_start, e_sel, e_t1, e_t2, e_allow, e_redir, e_busy;
      int e1, e2, total;
      @(negedge clk);
      kill2   = v1 && mis;
      l1m     = v1 && (lat1 != 0);
      l2m     = v2 && (lat2 != 0) && !kill2;
      e1      = l1m ? int'(lat1) : 0;
      e2      = l2m ? int'(lat2) : 0;
      total   = e1 + e2;
      ready   = (total == 0) || (m_age > total);
      e_busy  = (total != 0) && (m_age >= 1) && (m_age <= total);
      e_start = !flush && ((l1m && m_age == 0) || (l2m && m_age == e1));
      e_sel   = !(l1m && m_age == 0);
      e_t1    = v1 && ready && !flush;
      e_t2    = v2 && ready && !flush && !kill2;
      e_allow = !(v1 || v2) || (ready && nal);
      e_redir = kill2 && !m_rd && !flush;
      check("outputs{allow,t1,t2,start,redir,busy}", {allow, t1, t2, start, redir, busy},
            {e_allow, e_t1, e_t2, e_start, e_redir, e_busy});
      check("redirect_pc", pc, e_redir ? tgt : '0);
      if (e_start) check("mdu_sel", sel, e_sel);
      if (start) begin st_start++; st_last_start = st_cyc; end
      if (busy) st_busy++;
      if (redir) st_redir++;
      if (t1) st_t1++;
      if (t2) st_t2++;
      if (allow && st_first_allow < 0) st_first_allow = st_cyc;
      st_cyc++;
      @(posedge clk);
      if (!rst_n || flush || e_allow) begin
         m_age = 0; m_rd = 1'b0; new_b = 1'b1;
      end else begin
         m_age++;
         if (e_redir) m_rd = 1'b1;
         new_b = 1'b0;
      end
      #1;
   endtask

   task automatic run_bundle(input string name, input int budget);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!new_b && n < budget);
      check({name, "_completed"}, new_b, 1'b1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; v1 = 1'b0; v2 = 1'b0; lat1 = '0; lat2 = '0;
      mis = 1'b0; flush = 1'b0; nal = 1'b1;
      @(posedge clk);
      #1;
      m_age = 0; m_rd = 1'b0; new_b = 1'b1;
      check("reset_outputs", {allow, t1, t2, start, redir, busy, pc}, {1'b1, 37'd0});
      rst_n = 1'b1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      tgt = 32'h1C00_0040;
      // ctl = {v1, v2, mis, flush, nal}; exp = {allow, t1, t2, start, sel, redir}
      vecs[0]  = mk(5'b00000,  0, 0, 6'b100000);
      vecs[1]  = mk(5'b11001,  0, 0, 6'b111000);
      vecs[2]  = mk(5'b11000,  0, 0, 6'b011000);
      vecs[3]  = mk(5'b10001,  3, 0, 6'b000100);
      vecs[4]  = mk(5'b01001,  0, 5, 6'b000110);
      vecs[5]  = mk(5'b11101,  0, 4, 6'b110001);
      vecs[6]  = mk(5'b11101,  2, 0, 6'b000101);
      vecs[7]  = mk(5'b11011,  0, 0, 6'b100000);
      vecs[8]  = mk(5'b10110,  2, 0, 6'b000000);
      vecs[9]  = mk(5'b01101,  0, 0, 6'b101000);
      vecs[10] = mk(5'b10000,  0, 0, 6'b010000);
      vecs[11] = mk(5'b10001,  1, 0, 6'b000100);
      vecs[12] = mk(5'b11001, 63, 7, 6'b000100);

      for (int i = 0; i < 13; i++) begin
         do_reset();
         v1 = vecs[i].v1; v2 = vecs[i].v2; mis = vecs[i].mis;
         flush = vecs[i].flush; nal = vecs[i].nal;
         lat1 = vecs[i].lat1; lat2 = vecs[i].lat2;
         @(negedge clk);
         check($sformatf("vec%0d{allow,t1,t2,start,redir,busy}", i),
               {allow, t1, t2, start, redir, busy},
               {vecs[i].exp[5:2], vecs[i].exp[0], 1'b0});
         check($sformatf("vec%0d_pc", i), pc, vecs[i].exp[0] ? tgt : '0);
         if (vecs[i].exp[2]) check($sformatf("vec%0d_sel", i), sel, vecs[i].exp[1]);
      end

      // line1 divide, latency 3
      do_reset(); clr_stats();
      v1 = 1'b1; v2 = 1'b1; lat1 = 6'd3; lat2 = 6'd0;
      run_bundle("l1_div", 20);
      check("l1_div_busy_cycles", st_busy, 3);
      check("l1_div_starts", st_start, 1);
      check("l1_div_handoff_cycle", st_first_allow, 4);

      // serialized line1 + line2 MDU ops
      do_reset(); clr_stats();
      v1 = 1'b1; v2 = 1'b1; lat1 = 6'd2; lat2 = 6'd2;
      run_bundle("serial", 20);
      check("serial_starts", st_start, 2);
      check("serial_second_start_cycle", st_last_start, 2);
      check("serial_handoff_cycle", st_first_allow, 5);

      // mispredict under 5 cycles of backpressure
      do_reset(); clr_stats();
      v1 = 1'b1; v2 = 1'b1; lat1 = 6'd0; lat2 = 6'd0; mis = 1'b1; tgt = 32'h1C00_0040;
      nal = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      nal = 1'b1;
      tick();
      check("mispredict_redirect_pulses", st_redir, 1);
      check("mispredict_line2_valids", st_t2, 0);
      check("mispredict_release_cycle", st_first_allow, 5);
      check("mispredict_handoff", new_b, 1'b1);

      // exception flush while line1 op is in flight
      do_reset(); clr_stats();
      v1 = 1'b1; v2 = 1'b0; lat1 = 6'd8;
      for (int i = 0; i < 3; i++) tick();
      flush = 1'b1;
      tick();
      check("flush_busy_after_edge", busy, 1'b0);
      check("flush_no_to_next", st_t1 + st_t2, 0);
      flush = 1'b0; v1 = 1'b0;
      tick();

      // synchronous reset in the middle of a line2 op, then latency-1 bundle
      do_reset(); clr_stats();
      v1 = 1'b1; v2 = 1'b1; lat1 = 6'd0; lat2 = 6'd5;
      tick(); tick();
      check("l2_busy_before_reset", busy, 1'b1);
      do_reset(); clr_stats();
      v1 = 1'b1; v2 = 1'b1; lat1 = 6'd1; lat2 = 6'd0;
      run_bundle("post_reset_lat1", 10);
      check("post_reset_starts", st_start, 1);
      check("post_reset_busy_cycles", st_busy, 1);
      check("post_reset_handoff_cycle", st_first_allow, 2);

      // random bundles
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         if (new_b) begin
            v1 = ($urandom_range(0, 3) != 0);
            v2 = ($urandom_range(0, 3) != 0);
            lat1 = rnd_lat();
            lat2 = rnd_lat();
            mis = ($urandom_range(0, 3) == 0);
            tgt = $urandom;
         end
         flush = ($urandom_range(0, 24) == 0);
         nal = ($urandom_range(0, 2) != 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
